passcode_controller: RTL and testbench

- Keypad-side controller for the laser alarm.
- Collects digit strobes into an entry buffer and checks it against a stored code. Drives the one-cycle passcode_correct pulse consumed by the system state machine.
- Enforces a timed lockout after repeated failures.
- Supports a verified code-change sequence while the system is idle.

---
 rtl/passcode_if.sv | 29 ++
 rtl/passcode_controller.sv | 178 +++++++++++++++++
 tb/tb_passcode_controller.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/passcode_if.sv
// Keypad-to-controller bundle for the laser alarm passcode controller.
// master: keypad/system side driving strobes; slave: the controller.
interface passcode_if;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic       prog_req;
    logic       program_en;
    logic       passcode_correct;
    logic       passcode_wrong;
    logic       code_updated;
    logic       locked_out;
    logic [2:0] digit_count;
    logic [1:0] fail_count;
    logic [7:0] lockout_secs;

    modport master (
        output digit_valid, digit, enter, clear, prog_req, program_en,
        input  passcode_correct, passcode_wrong, code_updated, locked_out,
               digit_count, fail_count, lockout_secs
    );

    modport slave (
        input  digit_valid, digit, enter, clear, prog_req, program_en,
        output passcode_correct, passcode_wrong, code_updated, locked_out,
               digit_count, fail_count, lockout_secs
    );
endinterface

// File: rtl/passcode_controller.sv
// Keypad passcode controller: digit entry, code verification, timed lockout
// after repeated failures and a verified two-step code change.
module passcode_controller #(
    parameter int              DIGITS       = 4,
    parameter int              CLK_HZ       = 50000000,
    parameter int              MAX_TRIES    = 3,
    parameter int              LOCKOUT_S    = 10,
    parameter logic [DIGITS*4-1:0] DEFAULT_CODE = 16'h1234
) (
    input logic       clk,
    input logic       rst,
    passcode_if.slave bus
);
    localparam int CW = DIGITS * 4;
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    localparam logic [2:0] ST_ENTRY     = 3'd0;
    localparam logic [2:0] ST_CHECK     = 3'd1;
    localparam logic [2:0] ST_PROG_NEW  = 3'd2;
    localparam logic [2:0] ST_PROG_CONF = 3'd3;
    localparam logic [2:0] ST_LOCKOUT   = 3'd4;

    logic [2:0]    state;
    logic          auth_mode;
    logic [CW-1:0] buffer;
    logic [CW-1:0] stored_code;
    logic [CW-1:0] new_code;
    logic [2:0]    count_q;
    logic [1:0]    fail_q;
    logic [7:0]    secs_q;
    logic [PW-1:0] prescaler;
    logic          correct_q;
    logic          wrong_q;
    logic          updated_q;
    logic          locked_q;

    // prog_req only counts as a strobe when a code change is allowed; this
    // also decides whether it outranks a same-cycle digit.
    logic       prog_eff;
    logic       buf_full;
    logic       digit_ok;
    logic       match_stored;
    logic       match_new;
    logic       prescaler_wrap;
    logic [1:0] fail_next;

    assign prog_eff       = bus.prog_req & bus.program_en;
    assign buf_full       = (count_q == 3'(DIGITS));
    assign digit_ok       = bus.digit_valid & ~bus.clear & ~bus.enter & ~prog_eff
                          & (bus.digit <= 4'd9) & ~buf_full;
    assign match_stored   = buf_full && (buffer == stored_code);
    assign match_new      = buf_full && (buffer == new_code);
    assign prescaler_wrap = (prescaler == PW'(CLK_HZ - 1));
    assign fail_next      = fail_q + 2'd1;

    // NOTE: every register here, stored_code included, is plain flops rather
    // than a RAM, so all of it can take the asynchronous reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ENTRY;
            auth_mode   <= 1'b0;
            buffer      <= '0;
            stored_code <= DEFAULT_CODE;
            new_code    <= '0;
            count_q     <= '0;
            fail_q      <= '0;
            secs_q      <= '0;
            prescaler   <= '0;
            correct_q   <= 1'b0;
            wrong_q     <= 1'b0;
            updated_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values; the later writes below override
            // these pulse defaults.
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            updated_q <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    if (bus.clear) begin
                        buffer  <= '0;
                        count_q <= '0;
                    end else if (bus.enter) begin
                        state     <= ST_CHECK;
                        auth_mode <= 1'b0;
                    end else if (prog_eff) begin
                        state     <= ST_CHECK;
                        auth_mode <= 1'b1;
                    end else if (digit_ok) begin
                        buffer  <= {buffer[CW-5:0], bus.digit};
                        count_q <= count_q + 3'd1;
                    end
                end

                ST_CHECK: begin
                    buffer  <= '0;
                    count_q <= '0;
                    if (match_stored) begin
                        fail_q <= '0;
                        if (auth_mode) begin
                            state <= ST_PROG_NEW;
                        end else begin
                            correct_q <= 1'b1;
                            state     <= ST_ENTRY;
                        end
                    end else begin
                        wrong_q <= 1'b1;
                        fail_q  <= fail_next;
                        if (fail_next == 2'(MAX_TRIES)) begin
                            state     <= ST_LOCKOUT;
                            secs_q    <= 8'(LOCKOUT_S);
                            prescaler <= '0;
                            locked_q  <= 1'b1;
                        end else begin
                            state <= ST_ENTRY;
                        end
                    end
                end

                ST_PROG_NEW, ST_PROG_CONF: begin
                    if (!bus.program_en || bus.clear) begin
                        // Silent abort: drop everything typed so far.
                        buffer   <= '0;
                        count_q  <= '0;
                        new_code <= '0;
                        state    <= ST_ENTRY;
                    end else if (bus.enter) begin
                        buffer  <= '0;
                        count_q <= '0;
                        if (state == ST_PROG_NEW && buf_full) begin
                            new_code <= buffer;
                            state    <= ST_PROG_CONF;
                        end else begin
                            if (state == ST_PROG_CONF && match_new) begin
                                stored_code <= new_code;
                                updated_q   <= 1'b1;
                            end else begin
                                wrong_q <= 1'b1;
                            end
                            new_code <= '0;
                            state    <= ST_ENTRY;
                        end
                    end else if (digit_ok) begin
                        buffer  <= {buffer[CW-5:0], bus.digit};
                        count_q <= count_q + 3'd1;
                    end
                end

                ST_LOCKOUT: begin
                    if (prescaler_wrap) begin
                        prescaler <= '0;
                        secs_q    <= secs_q - 8'd1;
                        if (secs_q == 8'd1) begin
                            fail_q   <= '0;
                            locked_q <= 1'b0;
                            state    <= ST_ENTRY;
                        end
                    end else begin
                        prescaler <= prescaler + PW'(1);
                    end
                end

                default: state <= ST_ENTRY;
            endcase
        end
    end

    assign bus.passcode_correct = correct_q;
    assign bus.passcode_wrong   = wrong_q;
    assign bus.code_updated     = updated_q;
    assign bus.locked_out       = locked_q;
    assign bus.digit_count      = count_q;
    assign bus.fail_count       = fail_q;
    assign bus.lockout_secs     = secs_q;
endmodule

// File: tb/tb_passcode_controller.sv
// Bench for passcode_controller: vector table, directed multi-cycle sequences
// and random keypad traffic, all scored against a digit-list reference model.
module tb_passcode_controller;
    localparam int CLK_HZ    = 100;
    localparam int LOCKOUT_S = 10;
    localparam int MAX_TRIES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    passcode_if bus ();

    passcode_controller #(
        .DIGITS      (4),
        .CLK_HZ      (CLK_HZ),
        .MAX_TRIES   (MAX_TRIES),
        .LOCKOUT_S   (LOCKOUT_S),
        .DEFAULT_CODE(16'h1234)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: typed digits as a list, codes as digit arrays, and the
    // lockout as a plain count of remaining clock cycles.
    typedef enum {P_KEYPAD, P_JUDGE, P_NEWCODE, P_CONFIRM, P_LOCKED} phase_t;
    phase_t m_phase;
    int     typed[$];
    int     code_m[4];
    int     pend_m[4];
    bit     m_auth;
    int     m_tries;
    int     m_lock_left;
    bit     m_correct, m_wrong, m_updated;

    function automatic bit typed_is(input int ref_code[4]);
        if (typed.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (typed[i] != ref_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_phase = P_KEYPAD;
        typed.delete();
        code_m = '{1, 2, 3, 4};
        m_tries = 0;
        m_lock_left = 0;
        {m_correct, m_wrong, m_updated} = 3'b000;
    endtask

    task automatic model_step(input bit dv, input int d, input bit en, input bit cl,
                              input bit pr, input bit pe);
        {m_correct, m_wrong, m_updated} = 3'b000;
        case (m_phase)
            P_JUDGE: begin
                bit ok = typed_is(code_m);
                typed.delete();
                if (ok) begin
                    m_tries = 0;
                    if (m_auth) m_phase = P_NEWCODE;
                    else begin m_correct = 1; m_phase = P_KEYPAD; end
                end else begin
                    m_wrong = 1;
                    m_tries++;
                    if (m_tries == MAX_TRIES) begin
                        m_phase = P_LOCKED;
                        m_lock_left = LOCKOUT_S * CLK_HZ;
                    end else m_phase = P_KEYPAD;
                end
            end
            P_LOCKED: begin
                m_lock_left--;
                if (m_lock_left == 0) begin m_tries = 0; m_phase = P_KEYPAD; end
            end
            default: begin
                if (m_phase != P_KEYPAD && (!pe || cl)) begin
                    typed.delete();
                    m_phase = P_KEYPAD;
                end else if (cl) begin
                    typed.delete();
                end else if (en) begin
                    if (m_phase == P_KEYPAD) begin
                        m_phase = P_JUDGE;
                        m_auth = 0;
                    end else if (m_phase == P_NEWCODE) begin
                        if (typed.size() == 4) begin
                            for (int i = 0; i < 4; i++) pend_m[i] = typed[i];
                            m_phase = P_CONFIRM;
                        end else begin
                            m_wrong = 1;
                            m_phase = P_KEYPAD;
                        end
                        typed.delete();
                    end else begin
                        if (typed_is(pend_m)) begin code_m = pend_m; m_updated = 1; end
                        else m_wrong = 1;
                        typed.delete();
                        m_phase = P_KEYPAD;
                    end
                end else if (pr && pe) begin
                    if (m_phase == P_KEYPAD) begin m_phase = P_JUDGE; m_auth = 1; end
                end else if (dv && d <= 9 && typed.size() < 4) begin
                    typed.push_back(d);
                end
            end
        endcase
    endtask

    task automatic compare_model();
        check("correct",  bus.passcode_correct, m_correct);
        check("wrong",    bus.passcode_wrong, m_wrong);
        check("updated",  bus.code_updated, m_updated);
        check("locked",   bus.locked_out, m_phase == P_LOCKED);
        check("count",    bus.digit_count, typed.size());
        check("fails",    bus.fail_count, m_tries);
        check("secs",     bus.lockout_secs,
              (m_phase == P_LOCKED) ? (m_lock_left + CLK_HZ - 1) / CLK_HZ : 0);
    endtask

    bit pe_level = 1'b0;

    // One clock: drive at the falling edge, score at the next falling edge.
    task automatic apply(input bit dv, input int d, input bit en, input bit cl, input bit pr);
        bus.digit_valid = dv;
        bus.digit       = 4'(d);
        bus.enter       = en;
        bus.clear       = cl;
        bus.prog_req    = pr;
        bus.program_en  = pe_level;
        @(posedge clk);
        model_step(dv, d, en, cl, pr, pe_level);
        @(negedge clk);
        compare_model();
    endtask

    task automatic key(input int d);   apply(1, d, 0, 0, 0); endtask
    task automatic press_enter();      apply(0, 0, 1, 0, 0); endtask
    task automatic press_prog();       apply(0, 0, 0, 0, 1); endtask
    task automatic idle();             apply(0, 0, 0, 0, 0); endtask
    task automatic keys(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        compare_model();
    endtask

    typedef struct {
        bit dv; int d; bit en; bit cl; bit pr;
        int count; bit correct; bit wrong;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(bit dv, int d, bit en, bit cl, bit pr,
                                int count, bit correct, bit wrong);
        vec_t v;
        v.dv = dv; v.d = d; v.en = en; v.cl = cl; v.pr = pr;
        v.count = count; v.correct = correct; v.wrong = wrong;
        return v;
    endfunction

    initial begin
        bus.digit_valid = 0; bus.digit = 0; bus.enter = 0; bus.clear = 0;
        bus.prog_req = 0; bus.program_en = 0;
        model_reset();
        #12;
        check("rst_count",  bus.digit_count, 0);
        check("rst_secs",   bus.lockout_secs, 0);
        check("rst_pulses", {bus.passcode_correct, bus.passcode_wrong, bus.code_updated}, 0);
        do_reset();

        // Table: default-code verify, same-cycle strobes, invalid digits.
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 4, 0, 0, 0, 4, 0, 0));
        vecs.push_back(mk(1, 7, 0, 0, 0, 4, 0, 0));   // saturated
        vecs.push_back(mk(0, 0, 1, 0, 0, 4, 0, 0));   // enter -> check cycle
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));   // correct pulse
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));   // pulse is one cycle
        vecs.push_back(mk(1, 5, 0, 1, 0, 0, 0, 0));   // clear beats digit
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0));  // non-BCD ignored
        vecs.push_back(mk(1, 7, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));   // prog_req, program_en=0
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2, 0, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 4, 1, 0, 0, 3, 0, 0));   // enter beats 4th digit
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        foreach (vecs[i]) begin
            apply(vecs[i].dv, vecs[i].d, vecs[i].en, vecs[i].cl, vecs[i].pr);
            check($sformatf("vec%0d_count", i), bus.digit_count, vecs[i].count);
            check($sformatf("vec%0d_correct", i), bus.passcode_correct, vecs[i].correct);
            check($sformatf("vec%0d_wrong", i), bus.passcode_wrong, vecs[i].wrong);
        end

        // Lockout after three failures, then timed release.
        do_reset();
        key(1); key(2); key(3); press_enter(); idle();
        keys(9, 9, 9, 9); press_enter(); idle();
        keys(9, 9, 9, 9); press_enter(); idle();
        check("lock_wrong", bus.passcode_wrong, 1);
        check("lock_flag",  bus.locked_out, 1);
        check("lock_secs",  bus.lockout_secs, LOCKOUT_S);
        key(1);
        check("lock_ignores_digit", bus.digit_count, 0);
        begin
            int n = 0;
            while (bus.locked_out === 1'b1 && n < 1100) begin idle(); n++; end
            check("lockout_cycles", n, LOCKOUT_S * CLK_HZ - 1);
        end
        check("unlock_fails", bus.fail_count, 0);
        keys(1, 2, 3, 4); press_enter(); idle();
        check("unlock_verify", bus.passcode_correct, 1);

        // Successful code change to 5678.
        do_reset();
        pe_level = 1;
        keys(1, 2, 3, 4); press_prog(); idle();
        check("auth_no_correct", bus.passcode_correct, 0);
        keys(5, 6, 7, 8); press_enter();
        keys(5, 6, 7, 8); press_enter();
        check("code_updated", bus.code_updated, 1);
        pe_level = 0;
        keys(5, 6, 7, 8); press_enter(); idle();
        check("new_code_ok", bus.passcode_correct, 1);
        keys(1, 2, 3, 4); press_enter(); idle();
        check("old_code_bad", bus.passcode_wrong, 1);

        // Bad confirm, then abort by dropping program_en.
        do_reset();
        pe_level = 1;
        keys(1, 2, 3, 4); press_prog(); idle();
        keys(5, 6, 7, 8); press_enter();
        keys(5, 6, 7, 9); press_enter();
        check("confirm_wrong", bus.passcode_wrong, 1);
        check("confirm_no_update", bus.code_updated, 0);
        pe_level = 0;
        keys(1, 2, 3, 4); press_enter(); idle();
        check("code_kept", bus.passcode_correct, 1);
        pe_level = 1;
        keys(1, 2, 3, 4); press_prog(); idle();
        key(5); key(6);
        pe_level = 0;
        idle();
        check("abort_count", bus.digit_count, 0);
        check("abort_silent", {bus.passcode_wrong, bus.code_updated}, 0);

        // Asynchronous reset in the confirm step loses the pending code.
        pe_level = 1;
        keys(1, 2, 3, 4); press_prog(); idle();
        keys(5, 6, 7, 8); press_enter();
        key(5);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", bus.digit_count, 0);
        check("async_rst_flags", {bus.passcode_correct, bus.passcode_wrong,
                                  bus.code_updated, bus.locked_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        pe_level = 0;
        keys(1, 2, 3, 4); press_enter(); idle();
        check("post_rst_default", bus.passcode_correct, 1);

        // Random keypad traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r = $urandom_range(0, 99);
            bit dv, en, cl, pr;
            int d;
            if ($urandom_range(0, 63) == 0) pe_level = ~pe_level;
            cl = (r < 3);
            en = (r >= 3 && r < 12);
            pr = (r >= 12 && r < 16);
            dv = (r >= 16 && r < 85) || ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                             : code_m[typed.size() % 4];
            apply(dv, d, en, cl, pr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
